// File: rtl/axi_rom_slave.sv
// axi_rom_slave: AXI4 read-only ROM responder with FIXED/INCR/WRAP bursts and a programmable first-beat latency.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
module axi_rom_slave #(
   parameter int                    MEM_DEPTH    = 4096,
   parameter logic [`CPU_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
   parameter int                    READ_LATENCY = 2,
   parameter string                 INIT_FILE    = ""
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  s_arready,
   input  logic                  s_arvalid,
   input  logic [`CPU_WIDTH-1:0] s_araddr,
   input  logic [3:0]            s_arid,
   input  logic [7:0]            s_arlen,
   input  logic [2:0]            s_arsize,
   input  logic [1:0]            s_arburst,
   input  logic                  s_rready,
   output logic                  s_rvalid,
   output logic [1:0]            s_rresp,
   output logic [`CPU_WIDTH-1:0] s_rdata,
   output logic                  s_rlast,
   output logic [3:0]            s_rid
);
   localparam int W = `CPU_WIDTH;
   localparam int BYTES = W / 8;
   localparam int SZ = $clog2(BYTES);
   localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
   localparam longint unsigned SPAN = longint'(MEM_DEPTH) * BYTES;
   typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;
   state_t          state;
   logic [W-1:0]    mem [MEM_DEPTH];
   logic [W-1:0]    addr;
   logic [7:0]      len;
   logic [7:0]      beat;
   logic [2:0]      size;
   logic [1:0]      burst;
   logic [15:0]     cnt;
   logic [W-1:0]    step;
   logic [W-1:0]    win;
   logic [W-1:0]    addr_inc;
   logic [W-1:0]    addr_nxt;
   logic [W-1:0]    pa;
   logic [W-1:0]    off;
   logic            in_rng;
   logic [W-1:0]    pdata;
   logic [1:0]      presp;
   logic [7:0]      pbeat;
   logic [2:0]      extra;
   logic            gap;
`ifdef AXI_ROM_RAND_DELAY_EN
   logic [7:0] lfsr;
   always_ff @(posedge i_clk) begin
      if (i_rst) lfsr <= 8'hA5;
      else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign extra = lfsr[2:0];
   assign gap = lfsr[0];
`else
   assign extra = '0;
   assign gap = 1'b0;
`endif
   always_comb begin
      step = W'(1) << size;
      win = W'({1'b0, len} + 9'd1) << size;
      addr_inc = addr + step;
      addr_nxt = burst == 2'b00 ? addr :
                 burst == 2'b10 ? (addr & ~(win - W'(1))) | (addr_inc & (win - W'(1))) : addr_inc;
      pa = s_rvalid ? addr_nxt : addr;
      pbeat = s_rvalid ? beat + 8'd1 : beat;
      off = pa - BASE_ADDR;
      in_rng = pa >= BASE_ADDR && 64'(off) < SPAN;
      pdata = in_rng ? mem[off[SZ +: AW]] : '0;
      presp = (!in_rng || burst == 2'b11) ? 2'b10 : 2'b00;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         s_arready <= 1'b0;
         s_rvalid <= 1'b0;
         s_rresp <= '0;
         s_rdata <= '0;
         s_rlast <= 1'b0;
         s_rid <= '0;
         addr <= '0;
         len <= '0;
         beat <= '0;
         size <= '0;
         burst <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               s_arready <= 1'b1;
               if (s_arvalid && s_arready) begin
                  s_arready <= 1'b0;
                  s_rid <= s_arid;
                  addr <= s_araddr;
                  len <= s_arlen;
                  burst <= s_arburst;
                  size <= s_arsize > 3'(SZ) ? 3'(SZ) : s_arsize;
                  beat <= '0;
                  cnt <= 16'(READ_LATENCY) + 16'(extra);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 16'd0) begin
                  s_rvalid <= 1'b1;
                  s_rdata <= pdata;
                  s_rresp <= presp;
                  s_rlast <= pbeat == len;
                  state <= BEAT;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            BEAT: begin
               if (!s_rvalid) begin
                  s_rvalid <= 1'b1;
                  s_rdata <= pdata;
                  s_rresp <= presp;
                  s_rlast <= pbeat == len;
               end else if (s_rready) begin
                  if (s_rlast) begin
                     s_rvalid <= 1'b0;
                     s_arready <= 1'b1;
                     state <= IDLE;
                  end else begin
                     addr <= addr_nxt;
                     beat <= pbeat;
                     s_rvalid <= !gap;
                     s_rdata <= pdata;
                     s_rresp <= presp;
                     s_rlast <= pbeat == len;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_rom_slave.sv
// tb_axi_rom_slave: scoreboard bench for axi_rom_slave; expected beats are queued at AR issue and popped on R handshakes.
module tb_axi_rom_slave;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int DEPTH = 4096;
   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
      logic [3:0]  id;
   } beat_t;
   logic        i_clk;
   logic        i_rst;
   logic        s_arready;
   logic        s_arvalid;
   logic [31:0] s_araddr;
   logic [3:0]  s_arid;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst;
   logic        s_rready;
   logic        s_rvalid;
   logic [1:0]  s_rresp;
   logic [31:0] s_rdata;
   logic        s_rlast;
   logic [3:0]  s_rid;
   logic [31:0] tmem [DEPTH];
   beat_t       q[$];
   int          total = 0;
   int          bad = 0;
   axi_rom_slave dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .s_arready(s_arready), .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata),
      .s_rlast(s_rlast), .s_rid(s_rid)
   );
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   // Byte-address model of the burst sequence, independent of the DUT's mask arithmetic.
   task automatic model(input logic [31:0] a0, input logic [7:0] len, input logic [2:0] sz,
                        input logic [1:0] b, input logic [3:0] id);
      logic [31:0] a;
      logic [31:0] stp;
      logic [31:0] win;
      logic [31:0] wb;
      beat_t e;
      stp = 32'd1 << (sz > 3'd2 ? 3'd2 : sz);
      win = (32'(len) + 32'd1) * stp;
      wb = a0 - a0 % win;
      a = a0;
      for (int k = 0; k <= int'(len); k++) begin
         e.id = id;
         e.l = k == int'(len);
         if (a < BASE || 64'(a) >= 64'(BASE) + 64'(4 * DEPTH)) begin
            e.d = '0;
            e.r = 2'b10;
         end else begin
            e.d = tmem[(a - BASE) >> 2];
            e.r = b == 2'b11 ? 2'b10 : 2'b00;
         end
         q.push_back(e);
         a = b == 2'b00 ? a : b == 2'b10 ? wb + (a - wb + stp) % win : a + stp;
      end
   endtask
   task automatic ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                     input logic [1:0] b, input logic [3:0] id);
      int n;
      model(a, len, sz, b, id);
      @(negedge i_clk);
      s_arvalid = 1'b1;
      s_araddr = a;
      s_arlen = len;
      s_arsize = sz;
      s_arburst = b;
      s_arid = id;
      n = 0;
      while (!s_arready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk("ar_handshake", 64'(n < 50), 64'd1);
      @(posedge i_clk);
      #1 s_arvalid = 1'b0;
   endtask
   task automatic wait_rv();
      int n;
      @(negedge i_clk);
      n = 0;
      while (!s_rvalid && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk("rvalid_timeout", 64'(n < 50), 64'd1);
   endtask
   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain", 64'(q.size()), 64'd0);
      @(negedge i_clk);
   endtask
   always @(negedge i_clk) begin
      if (!i_rst && s_rvalid && s_rready) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            chk("rdata", 64'(s_rdata), 64'(q[0].d));
            chk("rresp", 64'(s_rresp), 64'(q[0].r));
            chk("rlast", 64'(s_rlast), 64'(q[0].l));
            chk("rid", 64'(s_rid), 64'(q[0].id));
            void'(q.pop_front());
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end
   initial begin
      int j;
      for (int i = 0; i < DEPTH; i++) begin
         tmem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
         dut.mem[i] = tmem[i];
      end
      tmem[1] = 32'h0000_0513;
      dut.mem[1] = tmem[1];
      i_rst = 1'b1;
      s_arvalid = 1'b0;
      s_araddr = '0;
      s_arid = '0;
      s_arlen = '0;
      s_arsize = '0;
      s_arburst = '0;
      s_rready = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("rst_arready", 64'(s_arready), 64'd0);
      chk("rst_rvalid", 64'(s_rvalid), 64'd0);
      chk("rst_rdata", 64'(s_rdata), 64'd0);
      chk("rst_rlast", 64'(s_rlast), 64'd0);
      chk("rst_rid", 64'(s_rid), 64'd0);
      chk("rst_rresp", 64'(s_rresp), 64'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      chk("rel_arready", 64'(s_arready), 64'd1);
      // single beat, first-beat latency
      ar(32'h8000_0004, 8'd0, 3'd2, 2'b01, 4'd3);
      @(negedge i_clk);
      j = 0;
      while (!s_rvalid && j < 30) begin
         @(negedge i_clk);
         j++;
      end
      chk("t1_latency", 64'(j), 64'd3);
      chk("t1_rdata", 64'(s_rdata), 64'h0000_0513);
      chk("t1_rlast", 64'(s_rlast), 64'd1);
      chk("t1_rid", 64'(s_rid), 64'd3);
      drain();
      // refill, back-to-back beats
      ar(32'h8000_0008, 8'd1, 3'd2, 2'b01, 4'd5);
      wait_rv();
      chk("t2_arready_busy", 64'(s_arready), 64'd0);
      chk("t2_first_last", 64'(s_rlast), 64'd0);
      @(negedge i_clk);
      chk("t2_b2b_valid", 64'(s_rvalid), 64'd1);
      chk("t2_b2b_last", 64'(s_rlast), 64'd1);
      @(negedge i_clk);
      chk("t2_done_rvalid", 64'(s_rvalid), 64'd0);
      chk("t2_done_arready", 64'(s_arready), 64'd1);
      drain();
      // refill with backpressure on beat 0
      s_rready = 1'b0;
      ar(32'h8000_0008, 8'd1, 3'd2, 2'b01, 4'd9);
      wait_rv();
      for (int i = 0; i < 3; i++) begin
         chk("t3_hold_valid", 64'(s_rvalid), 64'd1);
         chk("t3_hold_data", 64'(s_rdata), 64'(tmem[2]));
         chk("t3_hold_id", 64'(s_rid), 64'd9);
         chk("t3_hold_last", 64'(s_rlast), 64'd0);
         if (i < 2) @(negedge i_clk);
      end
      @(posedge i_clk);
      #1 s_rready = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("t3_b1_valid", 64'(s_rvalid), 64'd1);
      chk("t3_b1_data", 64'(s_rdata), 64'(tmem[3]));
      drain();
      // bursts of each type and width
      ar(32'h8000_0018, 8'd3, 3'd2, 2'b10, 4'd1);
      drain();
      ar(32'h8000_0020, 8'd2, 3'd2, 2'b00, 4'd2);
      drain();
      ar(32'h8000_0004, 8'd3, 3'd0, 2'b01, 4'd4);
      drain();
      ar(32'h8000_0030, 8'd1, 3'd2, 2'b11, 4'd6);
      drain();
      ar(32'h8000_0040, 8'd7, 3'd3, 2'b10, 4'd7);
      drain();
      // range boundaries
      ar(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'd8);
      drain();
      ar(32'h8000_000C, 8'd0, 3'd2, 2'b01, 4'd8);
      drain();
      ar(32'h8000_3FFC, 8'd1, 3'd2, 2'b01, 4'd10);
      drain();
      ar(32'h8000_4000, 8'd0, 3'd2, 2'b01, 4'd11);
      drain();
      // reset during beat 1
      ar(32'h8000_0010, 8'd3, 3'd2, 2'b01, 4'd12);
      wait_rv();
      @(posedge i_clk);
      #1 i_rst = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("t6_rst_rvalid", 64'(s_rvalid), 64'd0);
      chk("t6_rst_arready", 64'(s_arready), 64'd0);
      @(negedge i_clk);
      chk("t6_held_arready", 64'(s_arready), 64'd0);
      q.delete();
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      chk("t6_rel_arready", 64'(s_arready), 64'd1);
      ar(32'h8000_0014, 8'd1, 3'd2, 2'b01, 4'd13);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
